// File: rtl/npu_pkg.sv
// ----------------------------------------------------------------------------
// npu_pkg
// Shared types and constants for the NPU layer sequencer.
//   seq_state_t   : 4-bit sequencer state code (state_out encoding)
//   seq_err_t     : sticky error code reported on err_code
//   instruction_t : host instruction word pushed through the queue
//   activation_t  : activation function select
//   pooling_t     : pooling function select
// The immediate field packs the repeat count in its upper half and the
// compute cycle count in its lower half.
// ----------------------------------------------------------------------------
package npu_pkg;

   typedef logic [3:0] seq_state_t;

   localparam seq_state_t S_IDLE     = 4'h0;
   localparam seq_state_t S_FETCH    = 4'h1;
   localparam seq_state_t S_DECODE   = 4'h2;
   localparam seq_state_t S_LOAD_W   = 4'h3;
   localparam seq_state_t S_LOAD_A   = 4'h4;
   localparam seq_state_t S_COMPUTE  = 4'h5;
   localparam seq_state_t S_ACTIVATE = 4'h6;
   localparam seq_state_t S_POOL     = 4'h7;
   localparam seq_state_t S_WAIT_DMA = 4'h8;
   localparam seq_state_t S_STORE    = 4'h9;
   localparam seq_state_t S_NEXT     = 4'hA;
   localparam seq_state_t S_DONE     = 4'hB;
   localparam seq_state_t S_ERROR    = 4'hF;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_OPCODE  = 2'b10,
      ERR_ABORT   = 2'b11
   } seq_err_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_CONV  = 4'h1;
   localparam logic [3:0] OP_FC    = 4'h2;
   localparam logic [3:0] OP_POOL  = 4'h3;
   localparam logic [3:0] OP_ACT   = 4'h4;
   localparam logic [3:0] OP_LOAD  = 4'h5;
   localparam logic [3:0] OP_STORE = 4'h6;
   localparam logic [3:0] OP_SYNC  = 4'h7;

   // Field positions inside the 32-bit immediate.
   localparam int REPS_MSB  = 31;
   localparam int REPS_LSB  = 16;
   localparam int TOTAL_MSB = 15;
   localparam int TOTAL_LSB = 0;

   typedef enum logic [2:0] {
      ACT_NONE    = 3'd0,
      ACT_RELU    = 3'd1,
      ACT_RELU6   = 3'd2,
      ACT_SIGMOID = 3'd3,
      ACT_TANH    = 3'd4,
      ACT_GELU    = 3'd5,
      ACT_LEAKY   = 3'd6
   } activation_t;

   typedef enum logic [1:0] {
      POOL_MAX = 2'd0,
      POOL_AVG = 2'd1,
      POOL_MIN = 2'd2,
      POOL_SUM = 2'd3
   } pooling_t;

   // Address fields are carried at 32 bits; the sequencer uses the low ADDR_W.
   typedef struct packed {
      logic [3:0]  opcode;
      logic [7:0]  flags;
      logic [31:0] src0_addr;
      logic [31:0] src1_addr;
      logic [31:0] dst_addr;
      logic [31:0] immediate;
   } instruction_t;

   // A repeat count of zero still runs the instruction once.
   function automatic logic [15:0] seq_reps(input logic [31:0] imm);
      logic [15:0] r;
      r = imm[REPS_MSB:REPS_LSB];
      return (r == 16'd0) ? 16'd1 : r;
   endfunction

endpackage

// File: rtl/npu_inst_fifo.sv
// ----------------------------------------------------------------------------
// npu_inst_fifo
// Synchronous FIFO with flush. Read data is the head entry, valid while
// !empty. A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop all entries (wins over push/pop)
//   push, wr_data     : write request and data
//   pop, rd_data      : read request and head data
//   full, empty       : occupancy flags
// DEPTH must be a power of two, >= 2.
// ----------------------------------------------------------------------------
module npu_inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr_reg];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + (PTR_W+1)'(1);
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/npu_layer_sequencer.sv
// ----------------------------------------------------------------------------
// npu_layer_sequencer
// Instruction sequencer for the NPU: pops queued instructions, runs per-
// instruction repeat loops with strided buffer addressing, loads weights once
// per instruction, waits on pool/DMA completion under a watchdog and keeps a
// sticky error code.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start, enable, abort            : run request, stall when low, abort
//   busy, done, state_out           : status
//   instruction, inst_valid/ready   : instruction queue write port
//   cfg_act_stride, cfg_out_stride  : per-iteration address increments
//   cfg_timeout                     : watchdog limit (0 disables)
//   err_clear, err_code             : sticky error code and its clear
//   pe_*, act_*, pool_*             : datapath controls
//   weight_buf_*, act_buf_*         : buffer controls
//   dma_start, dma_channel, dma_done: DMA handshake
//   irq_done, irq_error             : one-cycle interrupts
// Optional build macro NPU_SEQ_PERF_EN adds perf_busy_cycles and
// perf_retired saturating counters.
// ----------------------------------------------------------------------------
module npu_layer_sequencer
   import npu_pkg::*;
#(
   parameter int PE_ROWS   = 16,
   parameter int ADDR_W    = 18,
   parameter int IQ_DEPTH  = 4,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 enable,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           state_out,
   input  instruction_t         instruction,
   input  logic                 inst_valid,
   output logic                 inst_ready,
   input  logic [ADDR_W-1:0]    cfg_act_stride,
   input  logic [ADDR_W-1:0]    cfg_out_stride,
   input  logic [TIMEOUT_W-1:0] cfg_timeout,
   input  logic                 err_clear,
   output logic                 pe_enable,
   output logic                 pe_clear_acc,
   output logic [PE_ROWS-1:0]   pe_load_weight,
   output activation_t          act_type,
   output logic                 act_enable,
   output pooling_t             pool_type,
   output logic                 pool_start,
   input  logic                 pool_done,
   output logic                 weight_buf_rd_en,
   output logic                 act_buf_rd_en,
   output logic                 act_buf_wr_en,
   output logic [ADDR_W-1:0]    weight_buf_addr,
   output logic [ADDR_W-1:0]    act_buf_addr,
   output logic                 dma_start,
   output logic [1:0]           dma_channel,
   input  logic                 dma_done,
   output logic                 irq_done,
   output logic                 irq_error,
   output logic [1:0]           err_code
`ifdef NPU_SEQ_PERF_EN
   ,
   output logic [31:0]          perf_busy_cycles,
   output logic [31:0]          perf_retired
`endif
);

   localparam int ROW_W = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;

   seq_state_t           state_reg, state_next;
   instruction_t         inst_reg;
   seq_err_t             err_reg;
   logic [15:0]          iter_reg, reps_reg, total_reg, cyc_reg;
   logic [ROW_W-1:0]     row_reg;
   logic [TIMEOUT_W-1:0] wd_reg;
   logic                 pulse_pending_reg;

   logic                 fifo_full, fifo_empty, push, pop;
   instruction_t         fifo_head;
   logic                 err_set;
   seq_err_t             err_new;
   logic                 row_last, cyc_last, wd_expire, more_iters;
   logic [16:0]          total_eff;
   logic                 unused_bits;

   assign inst_ready = !fifo_full;
   assign push       = inst_valid && inst_ready;
   assign pop        = (state_reg == S_FETCH) && enable && !fifo_empty && !abort;

   npu_inst_fifo #(
      .DEPTH (IQ_DEPTH),
      .WIDTH ($bits(instruction_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (abort),
      .push    (push),
      .wr_data (instruction),
      .pop     (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign row_last   = (row_reg == ROW_W'(PE_ROWS - 1));
   assign total_eff  = (total_reg == 16'd0) ? 17'd1 : {1'b0, total_reg};
   assign cyc_last   = ({1'b0, cyc_reg} + 17'd1) >= total_eff;
   assign more_iters = ({1'b0, iter_reg} + 17'd1) < {1'b0, reps_reg};
   // Watchdog fires on the cycle that would make the count equal the limit.
   assign wd_expire  = (cfg_timeout != '0) &&
                       (({1'b0, wd_reg} + (TIMEOUT_W+1)'(1)) == {1'b0, cfg_timeout});

   always_comb begin
      state_next = state_reg;
      err_set    = 1'b0;
      err_new    = ERR_NONE;
      if (enable) begin
         case (state_reg)
            S_IDLE:     if (start) state_next = S_FETCH;
            S_FETCH:    if (!fifo_empty) state_next = S_DECODE;
            S_DECODE: begin
               case (inst_reg.opcode)
                  OP_NOP:          state_next = S_FETCH;
                  OP_CONV, OP_FC:  state_next = S_LOAD_W;
                  OP_POOL, OP_ACT: state_next = S_LOAD_A;
                  OP_LOAD:         state_next = S_WAIT_DMA;
                  OP_STORE:        state_next = S_STORE;
                  OP_SYNC:         state_next = S_DONE;
                  default: begin
                     state_next = S_ERROR;
                     err_set    = 1'b1;
                     err_new    = ERR_OPCODE;
                  end
               endcase
            end
            S_LOAD_W:   if (row_last) state_next = S_LOAD_A;
            S_LOAD_A:   state_next = S_COMPUTE;
            S_COMPUTE:  if (cyc_last) state_next = (inst_reg.opcode == OP_POOL) ? S_POOL : S_ACTIVATE;
            S_ACTIVATE: state_next = S_STORE;
            S_POOL, S_WAIT_DMA: begin
               // Completion beats the watchdog when both land in one cycle.
               if ((state_reg == S_POOL) ? pool_done : dma_done) begin
                  state_next = S_STORE;
               end else if (wd_expire) begin
                  state_next = S_ERROR;
                  err_set    = 1'b1;
                  err_new    = ERR_TIMEOUT;
               end
            end
            S_STORE:    state_next = S_NEXT;
            S_NEXT: begin
               if (more_iters) begin
                  case (inst_reg.opcode)
                     OP_LOAD:  state_next = S_WAIT_DMA;
                     OP_STORE: state_next = S_STORE;
                     default:  state_next = S_LOAD_A;
                  endcase
               end else begin
                  state_next = S_FETCH;
               end
            end
            S_DONE, S_ERROR: state_next = S_IDLE;
            default:         state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= S_IDLE;
         inst_reg          <= '0;
         err_reg           <= ERR_NONE;
         iter_reg          <= '0;
         reps_reg          <= '0;
         total_reg         <= '0;
         cyc_reg           <= '0;
         row_reg           <= '0;
         wd_reg            <= '0;
         pulse_pending_reg <= 1'b0;
      end else if (abort) begin
         state_reg         <= S_IDLE;
         row_reg           <= '0;
         cyc_reg           <= '0;
         wd_reg            <= '0;
         pulse_pending_reg <= 1'b0;
         if (state_reg != S_IDLE) begin
            err_reg <= ERR_ABORT;
         end else if (err_clear) begin
            err_reg <= ERR_NONE;
         end
      end else begin
         if (err_set) begin
            err_reg <= err_new;
         end else if (err_clear) begin
            err_reg <= ERR_NONE;
         end
         if (enable) begin
            state_reg <= state_next;
            // Entry pulses stay armed across stalls until an enabled cycle.
            pulse_pending_reg <= (state_next != state_reg) &&
                                 ((state_next == S_POOL) || (state_next == S_WAIT_DMA));
            if (pop) begin
               inst_reg <= fifo_head;
            end
            case (state_reg)
               S_DECODE: begin
                  iter_reg  <= '0;
                  reps_reg  <= seq_reps(inst_reg.immediate);
                  total_reg <= inst_reg.immediate[TOTAL_MSB:TOTAL_LSB];
               end
               S_LOAD_W:  row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
               S_LOAD_A:  cyc_reg <= '0;
               S_COMPUTE: cyc_reg <= cyc_reg + 16'd1;
               S_POOL, S_WAIT_DMA: wd_reg <= (state_next != state_reg) ? '0 : wd_reg + TIMEOUT_W'(1);
               S_NEXT:    iter_reg <= iter_reg + 16'd1;
               default:   ;
            endcase
         end
      end
   end

   // Strided addresses wrap naturally at ADDR_W bits.
   logic [ADDR_W-1:0] act_rd_addr, act_wr_addr;
   assign act_rd_addr = inst_reg.src0_addr[ADDR_W-1:0] + ADDR_W'(ADDR_W'(iter_reg) * cfg_act_stride);
   assign act_wr_addr = inst_reg.dst_addr[ADDR_W-1:0]  + ADDR_W'(ADDR_W'(iter_reg) * cfg_out_stride);

   assign busy             = (state_reg != S_IDLE);
   assign done             = (state_reg == S_DONE);
   assign state_out        = state_reg;
   assign err_code         = err_reg;
   assign pe_enable        = enable && (state_reg == S_COMPUTE);
   assign pe_clear_acc     = enable && (state_reg == S_DECODE);
   assign act_enable       = enable && (state_reg == S_ACTIVATE);
   assign weight_buf_rd_en = enable && (state_reg == S_LOAD_W);
   assign act_buf_rd_en    = enable && ((state_reg == S_LOAD_A) || (state_reg == S_COMPUTE));
   assign act_buf_wr_en    = enable && (state_reg == S_STORE);
   assign pool_start       = enable && pulse_pending_reg && (state_reg == S_POOL);
   assign dma_start        = enable && pulse_pending_reg && (state_reg == S_WAIT_DMA);
   assign dma_channel      = inst_reg.flags[1:0];
   assign irq_done         = enable && (state_reg == S_DONE);
   assign irq_error        = enable && (state_reg == S_ERROR);
   assign weight_buf_addr  = inst_reg.src1_addr[ADDR_W-1:0] + ADDR_W'(row_reg);
   assign act_type         = (inst_reg.flags[2:0] == 3'd7) ? ACT_NONE : activation_t'(inst_reg.flags[2:0]);
   assign pool_type        = pooling_t'(inst_reg.flags[1:0]);

   always_comb begin
      act_buf_addr = '0;
      if ((state_reg == S_LOAD_A) || (state_reg == S_COMPUTE)) begin
         act_buf_addr = act_rd_addr;
      end else if (state_reg == S_STORE) begin
         act_buf_addr = act_wr_addr;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < PE_ROWS; gi++) begin : g_load_row
         assign pe_load_weight[gi] = weight_buf_rd_en && (row_reg == ROW_W'(gi));
      end
   endgenerate

   // Upper address bits and spare flag bits are carried but not consumed.
   assign unused_bits = ^{inst_reg.flags, inst_reg.src0_addr, inst_reg.src1_addr, inst_reg.dst_addr};

`ifdef NPU_SEQ_PERF_EN
   logic [31:0] perf_busy_reg, perf_retired_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_reg    <= '0;
         perf_retired_reg <= '0;
      end else if (start && (state_reg == S_IDLE)) begin
         perf_busy_reg    <= '0;
         perf_retired_reg <= '0;
      end else begin
         if (busy && enable && (perf_busy_reg != '1)) begin
            perf_busy_reg <= perf_busy_reg + 32'd1;
         end
         if (pop && (perf_retired_reg != '1)) begin
            perf_retired_reg <= perf_retired_reg + 32'd1;
         end
      end
   end

   assign perf_busy_cycles = perf_busy_reg;
   assign perf_retired     = perf_retired_reg;
`endif

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_npu_layer_sequencer
// Scoreboard bench: each expected buffer store is queued when its instruction
// is issued and checked against the DUT when act_buf_wr_en fires.
// ----------------------------------------------------------------------------
module tb_npu_layer_sequencer;
   import npu_pkg::*;

   localparam int PE_ROWS   = 16;
   localparam int ADDR_W    = 18;
   localparam int IQ_DEPTH  = 4;
   localparam int TIMEOUT_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                 start, enable, abort, busy, done, inst_valid, inst_ready;
   logic [3:0]           state_out;
   instruction_t         instruction;
   logic [ADDR_W-1:0]    cfg_act_stride, cfg_out_stride;
   logic [TIMEOUT_W-1:0] cfg_timeout;
   logic                 err_clear, pe_enable, pe_clear_acc, act_enable;
   logic [PE_ROWS-1:0]   pe_load_weight;
   activation_t          act_type;
   pooling_t             pool_type;
   logic                 pool_start, pool_done, weight_buf_rd_en, act_buf_rd_en, act_buf_wr_en;
   logic [ADDR_W-1:0]    weight_buf_addr, act_buf_addr;
   logic                 dma_start, dma_done, irq_done, irq_error;
   logic [1:0]           dma_channel, err_code;

   npu_layer_sequencer #(
      .PE_ROWS(PE_ROWS), .ADDR_W(ADDR_W), .IQ_DEPTH(IQ_DEPTH), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .abort(abort),
      .busy(busy), .done(done), .state_out(state_out),
      .instruction(instruction), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .cfg_act_stride(cfg_act_stride), .cfg_out_stride(cfg_out_stride),
      .cfg_timeout(cfg_timeout), .err_clear(err_clear),
      .pe_enable(pe_enable), .pe_clear_acc(pe_clear_acc), .pe_load_weight(pe_load_weight),
      .act_type(act_type), .act_enable(act_enable),
      .pool_type(pool_type), .pool_start(pool_start), .pool_done(pool_done),
      .weight_buf_rd_en(weight_buf_rd_en), .act_buf_rd_en(act_buf_rd_en),
      .act_buf_wr_en(act_buf_wr_en), .weight_buf_addr(weight_buf_addr),
      .act_buf_addr(act_buf_addr), .dma_start(dma_start), .dma_channel(dma_channel),
      .dma_done(dma_done), .irq_done(irq_done), .irq_error(irq_error), .err_code(err_code)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [ADDR_W-1:0] wr;
      logic [ADDR_W-1:0] wbase;
      int                pe;
      int                lw;
   } exp_t;

   exp_t sb[$];

   task automatic sb_add(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] wr,
                         input int pe, input int lw, input logic [ADDR_W-1:0] wbase);
      exp_t e;
      e.rd = rd; e.wr = wr; e.pe = pe; e.lw = lw; e.wbase = wbase;
      sb.push_back(e);
   endtask

   // ---------------- monitor ----------------
   int pe_cnt = 0, lw_cnt = 0, act_cnt = 0, dma_starts = 0, pool_starts = 0;
   int wd_cycles = 0, irq_err_cnt = 0, stores = 0;
   logic [ADDR_W-1:0] rd_seen = '0;
   logic [1:0] exp_chan = 2'd0;
   bit dma_auto = 1'b1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (abort) begin
            pe_cnt = 0;
            lw_cnt = 0;
         end else begin
            if (pe_enable) begin
               if (pe_cnt == 0) rd_seen = act_buf_addr;
               pe_cnt++;
            end
            if (|pe_load_weight) begin
               if (sb.size() > 0) begin
                  check("w_addr", weight_buf_addr, sb[0].wbase + ADDR_W'(lw_cnt));
                  check("lw_onehot", pe_load_weight, 16'h1 << lw_cnt);
               end
               lw_cnt++;
            end
            if (act_enable) act_cnt++;
            if (pool_start) pool_starts++;
            if (dma_start) begin
               dma_starts++;
               check("dma_chan", dma_channel, exp_chan);
            end
            if (irq_error) irq_err_cnt++;
            if (enable && state_out == 4'h8) wd_cycles++;
            if (act_buf_wr_en) begin
               if (sb.size() == 0) begin
                  check("sb_unexpected_store", sb.size(), 1);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("store %0d: addr=0x%0h pe=%0d lw=%0d", stores, act_buf_addr, pe_cnt, lw_cnt);
                  check("wr_addr", act_buf_addr, e.wr);
                  check("pe_cycles", pe_cnt, e.pe);
                  check("lw_cycles", lw_cnt, e.lw);
                  if (e.pe > 0) check("rd_addr", rd_seen, e.rd);
               end
               stores++;
               pe_cnt = 0;
               lw_cnt = 0;
            end
         end
      end
   end

   // ---------------- completion responders ----------------
   initial begin
      dma_done = 1'b0;
      forever begin
         @(negedge clk);
         if (dma_start && dma_auto) begin
            @(posedge clk); #1 dma_done = 1'b1;
            @(posedge clk); #1 dma_done = 1'b0;
         end
      end
   end

   initial begin
      pool_done = 1'b0;
      forever begin
         @(negedge clk);
         if (pool_start) begin
            @(posedge clk); #1 pool_done = 1'b1;
            @(posedge clk); #1 pool_done = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic instruction_t mk(input logic [3:0] op, input logic [7:0] fl,
                                       input logic [31:0] s0, input logic [31:0] s1,
                                       input logic [31:0] d, input logic [15:0] reps,
                                       input logic [15:0] total);
      instruction_t i;
      i.opcode = op; i.flags = fl; i.src0_addr = s0; i.src1_addr = s1;
      i.dst_addr = d; i.immediate = {reps, total};
      return i;
   endfunction

   task automatic push_inst(input instruction_t i);
      int b = 0;
      @(posedge clk); #1;
      instruction = i;
      inst_valid  = 1'b1;
      while (!inst_ready && b < 500) begin
         @(posedge clk); #1;
         b++;
      end
      if (b >= 500) check("push_ready_timeout", inst_ready, 1);
      @(posedge clk); #1;
      inst_valid = 1'b0;
   endtask

   task automatic pulse(input int which);
      @(posedge clk); #1;
      if (which == 0) start = 1'b1; else if (which == 1) abort = 1'b1; else err_clear = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; err_clear = 1'b0;
   endtask

   task automatic wait_irq(input string tag, input bit want_err, input int budget);
      bit found = 1'b0;
      for (int c = 0; c < budget && !found; c++) begin
         @(negedge clk);
         if (want_err ? irq_error : irq_done) found = 1'b1;
      end
      check(tag, found, 1);
   endtask

   task automatic wait_pe(input string tag, input int budget);
      bit found = 1'b0;
      for (int c = 0; c < budget && !found; c++) begin
         @(negedge clk);
         if (pe_enable) found = 1'b1;
      end
      check(tag, found, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   // ---------------- main sequence ----------------
   initial begin
      start = 0; enable = 1; abort = 0; inst_valid = 0; err_clear = 0;
      instruction = '0;
      cfg_act_stride = 18'h10; cfg_out_stride = 18'h20; cfg_timeout = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_state", state_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", inst_ready, 1);
      check("rst_err", err_code, 0);
      check("rst_pe", pe_enable, 0);
      check("rst_addr", act_buf_addr, 0);
      check("rst_lw", pe_load_weight, 0);

      // A: single CONV with a stall in the middle of compute
      sb_add(18'h40, 18'h300, 8, 16, 18'h200);
      push_inst(mk(OP_CONV, 8'h01, 32'h40, 32'h200, 32'h300, 16'd1, 16'd8));
      push_inst(mk(OP_SYNC, 8'h00, 0, 0, 0, 16'd0, 16'd0));
      pulse(0);
      wait_pe("a_pe_seen", 200);
      @(posedge clk); #1 enable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_pe", pe_enable, 0);
         check("stall_state", state_out, 5);
      end
      @(posedge clk); #1 enable = 1'b1;
      wait_irq("a_done", 1'b0, 300);
      check("a_sb_empty", sb.size(), 0);
      check("a_act_pulses", act_cnt, 1);
      @(negedge clk);
      check("a_idle", state_out, 0);

      // B: queue fill while idle, repeats, strides, DMA, pool, address wrap
      dma_starts = 0; pool_starts = 0; exp_chan = 2'd2;
      for (int k = 0; k < 3; k++)
         sb_add(18'h100 + 18'(k * 16), 18'h800 + 18'(k * 32), 2, (k == 0) ? 16 : 0, 18'h400);
      sb_add(0, 18'h50, 0, 0, 0);
      sb_add(0, 18'h70, 0, 0, 0);
      sb_add(18'h60, 18'h90, 1, 0, 0);
      sb_add(0, 18'h3FFF0, 0, 0, 0);
      sb_add(0, 18'h00010, 0, 0, 0);
      push_inst(mk(OP_CONV,  8'h07, 32'h100, 32'h400, 32'h800, 16'd3, 16'd2));
      push_inst(mk(OP_LOAD,  8'h02, 0, 0, 32'h50, 16'd2, 16'd0));
      push_inst(mk(OP_POOL,  8'h01, 32'h60, 0, 32'h90, 16'd0, 16'd0));
      push_inst(mk(OP_STORE, 8'h00, 0, 0, 32'h3FFF0, 16'd2, 16'd0));
      @(posedge clk); #1;
      instruction = mk(OP_SYNC, 8'h00, 0, 0, 0, 16'd0, 16'd0);
      inst_valid  = 1'b1;
      @(negedge clk);
      check("b_ready_full", inst_ready, 0);
      @(posedge clk); #1 inst_valid = 1'b0;
      pulse(0);
      push_inst(mk(OP_SYNC, 8'h00, 0, 0, 0, 16'd0, 16'd0));
      wait_irq("b_done", 1'b0, 1000);
      check("b_sb_empty", sb.size(), 0);
      check("b_dma_starts", dma_starts, 2);
      check("b_pool_starts", pool_starts, 1);

      // C: DMA never completes -> watchdog
      dma_auto = 1'b0; cfg_timeout = 16'd5; exp_chan = 2'd1;
      wd_cycles = 0; irq_err_cnt = 0;
      push_inst(mk(OP_LOAD, 8'h01, 0, 0, 32'h20, 16'd1, 16'd0));
      pulse(0);
      wait_irq("c_irq_err", 1'b1, 100);
      check("c_err_code", err_code, 2'b01);
      check("c_wait_cycles", wd_cycles, 5);
      @(negedge clk);
      check("c_idle", state_out, 0);
      check("c_irq_pulses", irq_err_cnt, 1);
      dma_auto = 1'b1; cfg_timeout = '0;

      // D: illegal opcode, then clear
      push_inst(mk(4'hC, 8'h00, 0, 0, 0, 16'd0, 16'd0));
      pulse(0);
      wait_irq("d_irq_err", 1'b1, 50);
      check("d_err_code", err_code, 2'b10);
      pulse(2);
      @(negedge clk);
      check("d_err_clr", err_code, 2'b00);

      // E: abort during COMPUTE flushes the queue
      push_inst(mk(OP_CONV, 8'h01, 32'h10, 32'h0, 32'h0, 16'd1, 16'd50));
      push_inst(mk(OP_SYNC, 8'h00, 0, 0, 0, 16'd0, 16'd0));
      pulse(0);
      wait_pe("e_pe_seen", 200);
      pulse(1);
      @(negedge clk);
      check("e_state", state_out, 0);
      check("e_busy", busy, 0);
      check("e_err_code", err_code, 2'b11);
      check("e_ready", inst_ready, 1);
      pulse(0);
      repeat (6) @(negedge clk);
      check("e_fetch_hold", state_out, 1);
      pulse(1);
      pulse(2);
      @(negedge clk);
      check("e_err_clr", err_code, 2'b00);
      check("e_final_idle", state_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
